dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameters SHALL be: DM_ADDRESS, default 9, byte-address width; DATA_W, default 32, data width; TIMEOUT, default 15, max cycles waiting for bus_ack.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1: single clock, all state on rising edge.
- reset in 1: synchronous, active-high.
- mem_read in 1: MEM-stage load request.
- mem_write in 1: MEM-stage store request.
- addr in DM_ADDRESS: byte address from EX/MEM ALU result.
- wr_data in DATA_W: store data, forwarded RS2.
- func3 in 3: RISC-V width/sign code.
- rd_data out DATA_W: extended load result to MEM/WB.
- stall out 1: freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB.
- misalign out 1: one-cycle pulse on misaligned access.
- bus_err out 1: one-cycle pulse on ack timeout.
- bus_req out 1, bus_we out 1, bus_addr out DM_ADDRESS-2 (word address), bus_be out 4, bus_wdata out DATA_W.
- bus_rdata in DATA_W, bus_ack in 1: word-wide memory side.

Function
REQ-003 access SHALL be mem_read|mem_write; if both are high, the access SHALL be a store only.
REQ-004 FSM states SHALL be IDLE, REQ, DONE.
REQ-005 IDLE transitions:
- aligned access -> REQ.
- misaligned access (half with addr[0]=1, word with addr[1:0]!=0) -> stay IDLE; misalign=1 that cycle; stall=0; no bus activity; rd_data=0.
- no access -> stay IDLE.
REQ-006 In REQ, bus_req SHALL be 1, and bus_addr, bus_we, bus_be and bus_wdata SHALL be held stable from registered copies until bus_ack.
REQ-007 On bus_ack in REQ, the FSM SHALL capture bus_rdata and go to DONE.
REQ-008 DONE SHALL last exactly one cycle with stall=0 and rd_data valid, then go to IDLE.
REQ-009 stall SHALL equal (state==IDLE & aligned access) | (state==REQ) (combinational).
REQ-010 Minimum latency: access seen at cycle 0, ack at cycle 1, DONE at cycle 2 (stall high cycles 0-1).
REQ-011 A wait counter SHALL increment each REQ cycle without ack.
REQ-012 On reaching TIMEOUT, the FSM SHALL:
- drop bus_req;
- pulse bus_err;
- go to DONE with rd_data=0.
REQ-013 The wait counter SHALL clear on leaving REQ.
REQ-014 Store enables:
- SB: bus_be=0001<<addr[1:0].
- SH: bus_be=0011<<addr[1:0].
- SW: bus_be=1111.
- bus_wdata: low byte/half replicated across lanes.
REQ-015 Load extraction from the captured word at addr[1:0]:
- LB/LH: sign-extend.
- LBU/LHU: zero-extend.
- LW: pass through.
- func3 011/110/111: treated as LW.
REQ-016 For loads, bus_be SHALL be 1111 and bus_we=0.
REQ-017 rd_data SHALL be 0 except in DONE after a load ack; stores SHALL return 0.
REQ-018 bus_ack outside REQ SHALL be ignored.

Reset
REQ-019 reset SHALL force:
- state=IDLE; wait counter=0;
- bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0;
- captured data=0;
- misalign=0, bus_err=0.
REQ-020 reset in REQ SHALL drop bus_req on the same edge, with no DONE cycle.
REQ-021 With reset=1 and access high, stall SHALL be 0.

Structure
REQ-022 The shared package dmem_pkg SHALL hold:
- dmem_state_t enum;
- func3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
- TIMEOUT default.
REQ-023 One combinational sub-module, load_align, SHALL implement REQ-015 (inputs word, addr[1:0], func3; output rd value).
REQ-024 The FSM, counter and store lane logic SHALL live in dmem_ctrl.

Verification
REQ-025 LW addr=0x010, ack next cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x04, stall high 2 cycles, DONE rd_data=0xDEADBEEF.
REQ-026 LB addr=0x013, rdata=0x80FFFFFF -> rd_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x012, rdata=0x8001ABCD -> 0x00008001.
REQ-027 SH addr=0x006, wr_data=0x1234ABCD -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1, rd_data=0.
REQ-028 LW addr=0x005 -> misalign pulse 1 cycle, bus_req never high, stall=0.
REQ-029 Load with bus_ack held low -> bus_req high 15 cycles, then bus_err pulse, DONE rd_data=0, IDLE.
REQ-030 reset asserted 2nd REQ cycle -> bus_req=0 next cycle, state IDLE, no rd_data update; late ack ignored.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEF = 15;

  // func3[1:0] selects size: 00 byte, 01 half, anything else is a word.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and extends a byte/half/word from a captured bus word.
module load_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        off,
  input  logic [2:0]        func3,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] sh;
  logic              sext;

  // Shift the addressed lane down, then extend by size; func3[2] marks unsigned.
  always_comb begin
    sh   = word >> {off, 3'b000};
    sext = ~func3[2];
    case (func3[1:0])
      2'b00:   rd = {{(DATA_W-8){sh[7] & sext}}, sh[7:0]};
      2'b01:   rd = {{(DATA_W-16){sh[15] & sext}}, sh[15:0]};
      default: rd = word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: IDLE/REQ/DONE handshake to a word bus,
// store lane steering, load extraction and an ack timeout.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  stall,
  output logic                  misalign,
  output logic                  bus_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DM_ADDRESS-3:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  dmem_state_t       state;
  logic [CW-1:0]     wait_cnt;
  logic [DATA_W-1:0] cap_data;
  logic              ld_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;

  logic              access, is_store, aligned;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic [DATA_W-1:0] ld_val;

  assign access   = mem_read | mem_write;
  assign is_store = mem_write;
  assign aligned  = is_aligned(func3, addr[1:0]);

  // Reset overrides everything so a frozen pipeline is released immediately.
  assign stall    = ~reset & (((state == IDLE) & access & aligned) | (state == REQ));
  assign misalign = ~reset & (state == IDLE) & access & ~aligned;

  // Store lane enables and replicated write data.
  always_comb begin
    case (func3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {(DATA_W/8){wr_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << addr[1:0];
        st_wdata = {(DATA_W/16){wr_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wr_data;
      end
    endcase
  end

  load_align #(.DATA_W(DATA_W)) u_align (
    .word  (cap_data),
    .off   (off_q),
    .func3 (f3_q),
    .rd    (ld_val)
  );

  // Only a completed load drives a value; a timeout leaves cap_data at zero.
  assign rd_data = ((state == DONE) & ld_q) ? ld_val : '0;

  // Handshake FSM with registered bus outputs and the ack wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'b0000;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cap_data  <= '0;
      bus_err   <= 1'b0;
      ld_q      <= 1'b0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          bus_err <= 1'b0;
          if (access & aligned) begin
            state     <= REQ;
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= addr[DM_ADDRESS-1:2];
            bus_be    <= is_store ? st_be : 4'b1111;
            bus_wdata <= is_store ? st_wdata : '0;
            ld_q      <= ~is_store;
            off_q     <= addr[1:0];
            f3_q      <= func3;
          end
        end
        REQ: begin
          if (bus_ack) begin
            cap_data <= bus_rdata;
            bus_req  <= 1'b0;
            wait_cnt <= '0;
            state    <= DONE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            cap_data <= '0;
            bus_req  <= 1'b0;
            bus_err  <= 1'b1;
            wait_cnt <= '0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          bus_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl with a transaction-level reference model.
module tb_dmem_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk, reset, mem_read, mem_write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, rd_data, bus_wdata, bus_rdata;
  logic [2:0]    func3;
  logic          stall, misalign, bus_err, bus_req, bus_we, bus_ack;
  logic [AW-3:0] bus_addr;
  logic [3:0]    bus_be;

  dmem_ctrl #(.DM_ADDRESS(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wr_data(wr_data), .func3(func3), .rd_data(rd_data),
    .stall(stall), .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-cycle expectations written by the stimulus thread.
  logic          chk_en = 1'b0;
  logic          e_stall, e_mis, e_err, e_req, e_we, e_chkw, e_done;
  logic [AW-3:0] e_addr;
  logic [3:0]    e_be;
  logic [DW-1:0] e_wdata, e_rd;

  // Observations used by the literal directed checks.
  int            req_cnt, stall_cnt, mis_cnt, err_cnt;
  logic [DW-1:0] last_rd, last_wdata;
  logic [AW-3:0] last_addr;
  logic [3:0]    last_be;
  logic          last_we;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: size from func3, alignment, extension, lanes.
  function automatic int sz(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [DW-1:0] m_ext(input logic [DW-1:0] w, input logic [1:0] off,
                                          input logic [2:0] f3);
    int n;
    logic [DW-1:0] v, m;
    n = sz(f3);
    if (n == 4) return w;
    m = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = (w >> (8 * int'(off))) & m;
    if (!f3[2] && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic st, input logic [1:0] off, input logic [2:0] f3);
    logic [3:0] t;
    if (!st || sz(f3) == 4) return 4'hF;
    t = 4'((1 << sz(f3)) - 1);
    return t << off;
  endfunction

  function automatic logic [DW-1:0] m_wdata(input logic [DW-1:0] wd, input logic [2:0] f3);
    case (sz(f3))
      1:       return {4{wd[7:0]}};
      2:       return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // The single compare process: checks outputs every cycle against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("misalign", {31'd0, misalign}, {31'd0, e_mis});
      chk("bus_err", {31'd0, bus_err}, {31'd0, e_err});
      chk("bus_req", {31'd0, bus_req}, {31'd0, e_req});
      chk("rd_data", rd_data, e_rd);
      if (e_req) begin
        chk("bus_we", {31'd0, bus_we}, {31'd0, e_we});
        chk("bus_addr", {25'd0, bus_addr}, {25'd0, e_addr});
        chk("bus_be", {28'd0, bus_be}, {28'd0, e_be});
        if (e_chkw) chk("bus_wdata", bus_wdata, e_wdata);
      end
      if (bus_req) begin
        req_cnt++;
        last_addr  = bus_addr;
        last_be    = bus_be;
        last_we    = bus_we;
        last_wdata = bus_wdata;
      end
      if (stall)    stall_cnt++;
      if (misalign) mis_cnt++;
      if (bus_err)  err_cnt++;
      if (e_done)   last_rd = rd_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp;
    e_stall = 1'b0; e_mis = 1'b0; e_err = 1'b0; e_req = 1'b0;
    e_rd = '0; e_done = 1'b0; e_chkw = 1'b0;
  endtask

  task automatic drop_inputs;
    mem_read = 1'b0; mem_write = 1'b0;
    bus_ack  = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
  endtask

  // One access. lat = REQ cycle (1-based) carrying ack, > TO means never.
  // rst_at = REQ cycle in which reset is asserted, 0 for none.
  task automatic xact(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [2:0] f3, input int lat,
                      input logic [DW-1:0] rdata, input int rst_at);
    logic st;
    st = wr;
    tick;
    mem_read = rd; mem_write = wr; addr = a; wr_data = wd; func3 = f3;
    bus_ack = 1'($urandom_range(0, 1));
    req_cnt = 0; stall_cnt = 0; mis_cnt = 0; err_cnt = 0; last_rd = 'x;
    idle_exp;
    if ((int'(a) % sz(f3)) != 0) begin
      e_mis = 1'b1;
      tick;
      drop_inputs; idle_exp;
      return;
    end
    e_stall = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      tick;
      e_req = 1'b1; e_stall = 1'b1; e_we = st; e_addr = a[AW-1:2];
      e_be = m_be(st, a[1:0], f3); e_chkw = st; e_wdata = m_wdata(wd, f3);
      if (k == rst_at) begin
        reset = 1'b1; bus_ack = 1'b0; e_stall = 1'b0;
        tick;
        reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        idle_exp;
        tick;
        drop_inputs; idle_exp;
        return;
      end
      bus_ack   = (k == lat);
      bus_rdata = (k == lat) ? rdata : $urandom;
      if (k == lat) break;
    end
    tick;
    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    e_req = 1'b0; e_stall = 1'b0; e_done = 1'b1; e_chkw = 1'b0;
    e_err = (lat > TO);
    e_rd  = (!st && lat <= TO) ? m_ext(rdata, a[1:0], f3) : '0;
    tick;
    drop_inputs; idle_exp;
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wr_data = '0;
    func3 = 3'b010; bus_rdata = '0; bus_ack = 1'b0;
    idle_exp; e_we = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0;
    tick;
    // Access held high while in reset must not stall.
    mem_read = 1'b1; addr = 9'h010; chk_en = 1'b1;
    tick;
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_bus_addr", {25'd0, bus_addr}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    reset = 1'b0; mem_read = 1'b0;

    // Directed cases with hand-computed results.
    xact(1'b1, 1'b0, 9'h010, '0, 3'b010, 1, 32'hDEAD_BEEF, 0);
    chk("lw_rd", last_rd, 32'hDEAD_BEEF);
    chk("lw_bus_addr", {25'd0, last_addr}, 32'h04);
    chk("lw_stall_cycles", stall_cnt, 2);
    chk("lw_req_cycles", req_cnt, 1);

    xact(1'b1, 1'b0, 9'h013, '0, 3'b000, 1, 32'h80FF_FFFF, 0);
    chk("lb_rd", last_rd, 32'hFFFF_FF80);
    xact(1'b1, 1'b0, 9'h013, '0, 3'b100, 2, 32'h80FF_FFFF, 0);
    chk("lbu_rd", last_rd, 32'h0000_0080);
    xact(1'b1, 1'b0, 9'h012, '0, 3'b101, 1, 32'h8001_ABCD, 0);
    chk("lhu_rd", last_rd, 32'h0000_8001);

    xact(1'b0, 1'b1, 9'h006, 32'h1234_ABCD, 3'b001, 1, 32'h5555_5555, 0);
    chk("sh_be", {28'd0, last_be}, 32'b1100);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_we", {31'd0, last_we}, 32'd1);
    chk("sh_rd", last_rd, 32'd0);

    xact(1'b1, 1'b0, 9'h005, '0, 3'b010, 1, 32'h1111_1111, 0);
    chk("mis_pulses", mis_cnt, 1);
    chk("mis_req_cycles", req_cnt, 0);
    chk("mis_stall_cycles", stall_cnt, 0);

    xact(1'b1, 1'b0, 9'h020, '0, 3'b010, 99, 32'h2222_2222, 0);
    chk("to_req_cycles", req_cnt, 15);
    chk("to_err_pulses", err_cnt, 1);
    chk("to_rd", last_rd, 32'd0);

    xact(1'b1, 1'b0, 9'h040, '0, 3'b010, 5, 32'h3333_3333, 2);
    chk("rst_req_cycles", req_cnt, 2);

    xact(1'b1, 1'b1, 9'h044, 32'hA5A5_5A5A, 3'b010, 1, 32'h7777_7777, 0);
    chk("rw_is_store_we", {31'd0, last_we}, 32'd1);
    chk("rw_is_store_rd", last_rd, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      logic rd, wr;
      logic [2:0] f3;
      int lat, rst_at, r;
      r  = $urandom_range(0, 2);
      rd = (r != 1);
      wr = (r != 0);
      f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      lat = (r < 7) ? 1 + (r % 3) : (r == 7) ? 20 : (r == 8) ? 15 : 14;
      rst_at = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 2) : 0;
      if (rst_at != 0 && lat <= rst_at) lat = rst_at + 1;
      xact(rd, wr, 9'($urandom_range(0, 511)), $urandom, f3, lat, $urandom, rst_at);
    end

    tick;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
